// File: rtl/shift_normalizer.sv
// shift_normalizer
//
// Normalizes a 16-bit operand so that its MSB is set. The leading-zero count is
// found serially, one bit per cycle from bit 15 down. The shift itself is done by
// an external Left_Barrel_Shifter that this block drives through sh_data/sh_control.
// One operand is in flight at a time.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand offered
//   in_ready    block is idle and can accept an operand
//   in_data     operand to normalize
//   sh_data     barrel shifter data input (operand register)
//   sh_control  barrel shifter shift amount (count register, low 4 bits)
//   sh_result   barrel shifter result, combinational from sh_data/sh_control
//   out_valid   normalized result available
//   out_ready   consumer accepts the result
//   out_data    normalized operand, MSB set unless out_zero
//   out_count   leading-zero count applied, 0..16
//   out_zero    operand was zero

module shift_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] sh_data,
    output logic [3:0]  sh_control,
    input  logic [15:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [4:0]  out_count,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] operand_q, operand_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] out_data_q, out_data_d;
    logic [4:0]  out_count_q, out_count_d;
    logic        out_zero_q, out_zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            operand_q   <= 16'h0000;
            index_q     <= 4'd0;
            count_q     <= 5'd0;
            out_data_q  <= 16'h0000;
            out_count_q <= 5'd0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            index_q     <= index_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        operand_d   = operand_q;
        index_d     = index_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    operand_d = in_data;
                    index_d   = 4'd15;
                    count_d   = 5'd0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (operand_q[index_q]) begin
                    count_d = 5'd15 - {1'b0, index_q};
                    state_d = StShift;
                end else if (index_q != 4'd0) begin
                    index_d = index_q - 4'd1;
                    count_d = count_q + 5'd1;
                end else begin
                    // All-zero operand: skip the shifter. count goes to 16 so that
                    // sh_control (count[3:0]) settles back at 0.
                    count_d     = 5'd16;
                    out_data_d  = 16'h0000;
                    out_count_d = 5'd16;
                    out_zero_d  = 1'b1;
                    state_d     = StDone;
                end
            end
            StShift: begin
                // sh_control has held count since the SCAN->SHIFT edge, so
                // sh_result is already the shifted operand.
                out_data_d  = sh_result;
                out_count_d = count_q;
                out_zero_d  = 1'b0;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign sh_data    = operand_q;
    assign sh_control = count_q[3:0];
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// tb_shift_normalizer
//
// Directed bench for shift_normalizer. The external Left_Barrel_Shifter is modelled
// by a plain combinational left shift of sh_data by sh_control.

module tb_shift_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] sh_data;
    logic [3:0]  sh_control;
    logic [15:0] sh_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_count;
    logic        out_zero;

    int n_vec;
    int n_miss;

    shift_normalizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sh_data    (sh_data),
        .sh_control (sh_control),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_zero   (out_zero)
    );

    // Left_Barrel_Shifter stand-in
    assign sh_result = sh_data << sh_control;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid after an accepting edge, sampling #1 after each edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Offer one operand with out_ready high and check the result and latency.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [15:0] exp_data,
                          input logic [4:0] exp_count, input logic exp_zero, input int exp_lat);
        int lat;
        @(negedge clk);
        check_val({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val({tag, " busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " data"}, 32'(out_data), 32'(exp_data));
        check_val({tag, " count"}, 32'(out_count), 32'(exp_count));
        check_val({tag, " zero"}, 32'(out_zero), 32'(exp_zero));
        check_val({tag, " sh_data"}, 32'(sh_data), 32'(d));
        check_val({tag, " sh_control"}, 32'(sh_control), 32'(exp_count[3:0]));
        @(posedge clk);
        #1;
        check_val({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check_val({tag, " idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst out_valid", 32'(out_valid), 32'd0);
        check_val("rst out_data", 32'(out_data), 32'd0);
        check_val("rst out_count", 32'(out_count), 32'd0);
        check_val("rst sh_data", 32'(sh_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst in_ready", 32'(in_ready), 32'd1);

        run_op("f9ce", 16'hF9CE, 16'hF9CE, 5'd0, 1'b0, 2);
        run_op("0001", 16'h0001, 16'h8000, 5'd15, 1'b0, 17);
        run_op("00f0", 16'h00F0, 16'hF000, 5'd8, 1'b0, 10);
        run_op("zero", 16'h0000, 16'h0000, 5'd16, 1'b1, 16);

        // Backpressure: 0x0C00 has 4 leading zeros -> 0xC000. 0x1234 stays offered
        // meanwhile; 3 leading zeros -> 0x1234 << 3 = 0x91A0.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0C00;
        @(posedge clk);
        #1;
        in_data = 16'h1234;
        wait_valid(lat);
        check_val("bp latency", 32'(lat), 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp hold valid", 32'(out_valid), 32'd1);
            check_val("bp hold data", 32'(out_data), 32'hC000);
            check_val("bp hold count", 32'(out_count), 32'd4);
            check_val("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp release valid", 32'(out_valid), 32'd0);
        check_val("bp release idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check_val("bp2 latency", 32'(lat), 32'd5);
        check_val("bp2 data", 32'(out_data), 32'h91A0);
        check_val("bp2 count", 32'(out_count), 32'd3);
        @(posedge clk);
        #1;

        // Reset in the middle of scanning 0x0008.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0008;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("mid scan busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("async valid", 32'(out_valid), 32'd0);
        check_val("async data", 32'(out_data), 32'd0);
        check_val("async count", 32'(out_count), 32'd0);
        check_val("async zero", 32'(out_zero), 32'd0);
        check_val("async sh_data", 32'(sh_data), 32'd0);
        check_val("async sh_control", 32'(sh_control), 32'd0);
        check_val("async in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post rst ready", 32'(in_ready), 32'd1);
        check_val("post rst valid", 32'(out_valid), 32'd0);
        run_op("4000", 16'h4000, 16'h8000, 5'd1, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
